minterm_extractor: RTL and testbench

MINTERM_EXTRACTOR -- requirements
Module: minterm_extractor

---
 rtl/minterm_pkg.sv | 12 +
 rtl/minterm_extractor.sv | 100 ++++++++++
 tb/tb_minterm_extractor.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/minterm_pkg.sv
// Shared constants for the minterm extractor.
// FSM state encodings and default variable count.
package minterm_pkg;

  localparam int N_DEFAULT = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/minterm_extractor.sv
// Sweeps an external N-input function, captures its truth table,
// then streams the indices of its minterms over a valid/ready port.
module minterm_extractor
  import minterm_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N-1:0]    vec,
  input  logic            f_in,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N-1:0]    m_index,
  output logic [2**N-1:0] tt,
  output logic [N:0]      count,
  output logic            busy,
  output logic            done
);

  localparam int M = 2**N;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] vec_q, vec_d;
  logic [N-1:0] p_q, p_d;
  logic [M-1:0] tt_q, tt_d;
  logic [N:0]   count_q, count_d;

  logic last_vec;
  logic last_p;
  logic hit;

  assign last_vec = (vec_q == {N{1'b1}});
  assign last_p   = (p_q == {N{1'b1}});
  assign hit      = tt_q[p_q];

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    p_d     = p_q;
    tt_d    = tt_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          vec_d   = '0;
          tt_d    = '0;
          count_d = '0;
          p_d     = '0;
        end
      end
      S_SWEEP: begin
        // f_in reflects vec_q, which has been stable a full cycle
        tt_d[vec_q] = f_in;
        count_d     = count_q + (N+1)'(f_in);
        if (last_vec) begin
          state_d = S_EMIT;
          p_d     = '0;
        end else begin
          vec_d = vec_q + N'(1);
        end
      end
      S_EMIT: begin
        if (!hit || m_ready) begin
          if (last_p) state_d = S_DONE;
          else        p_d     = p_q + N'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      p_q     <= '0;
      tt_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      p_q     <= p_d;
      tt_q    <= tt_d;
      count_q <= count_d;
    end
  end

  assign vec     = vec_q;
  assign tt      = tt_q;
  assign count   = count_q;
  assign m_valid = (state_q == S_EMIT) && hit;
  assign m_index = m_valid ? p_q : '0;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_minterm_extractor.sv
// Scoreboard bench for minterm_extractor (N=4).
// Directed runs: sample function, constants, backpressure, restart, reset.
module tb_minterm_extractor;

  localparam int N = 4;
  localparam int M = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] vec;
  logic         f_in;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [N-1:0] m_index;
  logic [M-1:0] tt;
  logic [N:0]   count;
  logic         busy;
  logic         done;

  int mode = 0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];

  logic fa, fb, fc, fd, func;

  minterm_extractor #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vec(vec), .f_in(f_in),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_index(m_index), .tt(tt),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign fa = vec[3];
  assign fb = vec[2];
  assign fc = vec[1];
  assign fd = vec[0];
  assign func = (!fb && !fd) || (!fa && fb && fd) || (fa && fb && !fc);
  assign f_in = (mode == 0) ? func : (mode == 2);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops on every handshake, checks stability under stall
  bit           pend = 0;
  logic [N-1:0] pend_idx;
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        checks++;
        if (!m_valid || m_index !== pend_idx) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b idx=%0d expected v=1 idx=%0d",
                   m_valid, m_index, pend_idx);
        end
      end
      if (m_valid) begin
        if (m_ready) begin
          pend = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL emit_unexpected: got idx=%0d expected none",
                     m_index);
          end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(m_index) != e) begin
              errors++;
              $display("FAIL emit_index: got %0d expected %0d", m_index, e);
            end
          end
        end else begin
          pend = 1;
          pend_idx = m_index;
        end
      end else begin
        pend = 0;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_vec"}, 32'(vec), 0);
    chk({tag, "_tt"}, 32'(tt), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_mvalid"}, 32'(m_valid), 0);
    chk({tag, "_mindex"}, 32'(m_index), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic run(input string tag, input int exp_done,
                     input logic [M-1:0] exp_tt, input int exp_cnt,
                     input bit stall_en, input bit restart_en,
                     input bit rst_en);
    int  cyc;
    int  stall_n;
    bit  stalled;
    bit  restarted;
    bit  aborted;
    stall_n = 0;
    stalled = 0;
    restarted = 0;
    aborted = 0;
    m_ready = 1'b1;
    for (int k = 0; k < M; k++)
      if (exp_tt[k]) exp_q.push_back(k);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_start"}, 32'(busy), 1);
    while (!done && !aborted && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (stall_en && !stalled && m_valid && m_index == 4'd5) begin
        m_ready = 1'b0;
        stall_n = 3;
        stalled = 1;
      end else if (stall_n > 0) begin
        stall_n--;
        if (stall_n == 0) m_ready = 1'b1;
      end
      if (restart_en && !restarted && vec == 4'd6) begin
        start = 1'b1;
        restarted = 1;
      end
      if (rst_en && m_valid && m_index == 4'd5) begin
        rst = 1'b1;
        #1;
        aborted = 1;
      end
    end
    if (aborted) begin
      check_zero({tag, "_abort"});
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk({tag, "_idle_busy"}, 32'(busy), 0);
      chk({tag, "_idle_mvalid"}, 32'(m_valid), 0);
    end else begin
      chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_tt"}, 32'(tt), 32'(exp_tt));
      chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
      chk({tag, "_vec"}, 32'(vec), 15);
      chk({tag, "_left"}, 32'(exp_q.size()), 0);
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        #1;
        chk({tag, "_done_after"}, 32'(done), 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
      end
      chk({tag, "_tt_hold"}, 32'(tt), 32'(exp_tt));
      chk({tag, "_vec_hold"}, 32'(vec), 15);
    end
  endtask

  initial begin
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("post_reset");

    mode = 0;
    run("func", 33, 16'h35A5, 8, 0, 0, 0);
    mode = 1;
    run("zero", 33, 16'h0000, 0, 0, 0, 0);
    mode = 2;
    run("one", 33, 16'hFFFF, 16, 0, 0, 0);
    mode = 0;
    run("stall", 36, 16'h35A5, 8, 1, 0, 0);
    run("restart", 33, 16'h35A5, 8, 0, 1, 0);
    run("abort", 33, 16'h35A5, 8, 0, 0, 1);
    run("rerun", 33, 16'h35A5, 8, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
